// File: rtl/bbox_test_scheduler.sv
// bbox_test_scheduler: round-robin issue of box tests into one shared fixed-latency intersect unit.
// Define BBOX_SCHED_PERF_EN to add saturating perf_issued/perf_hits/perf_stall_cycles counters.
module bbox_test_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int ID_W      = $clog2(NUM_REQ),
    parameter int PAYLOAD_W = 512,
    parameter int UNIT_LAT  = 2,
    parameter int DIST_W    = 49
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*PAYLOAD_W-1:0] req_payload,
    input  logic                         flush,
    output logic [PAYLOAD_W-1:0]         unit_payload,
    output logic                         unit_stall,
    input  logic                         unit_hit,
    input  logic [DIST_W-1:0]            unit_dist,
`ifdef BBOX_SCHED_PERF_EN
    output logic [31:0]                  perf_issued,
    output logic [31:0]                  perf_hits,
    output logic [31:0]                  perf_stall_cycles,
`endif
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [ID_W-1:0]              rsp_id,
    output logic                         rsp_hit,
    output logic [DIST_W-1:0]            rsp_dist
);
    logic [ID_W-1:0]                 ptr_q, ptr_d, gnt_id;
    logic                            gnt;
    int                              best, dist_rr;
    logic [PAYLOAD_W-1:0]            pay_q, pay_d;
    logic [UNIT_LAT-1:0]             tv_q, tv_d;
    logic [UNIT_LAT-1:0][ID_W-1:0]   tid_q, tid_d;
    logic                            rv_q, rv_d, rhit_q, rhit_d;
    logic [ID_W-1:0]                 rid_q, rid_d;
    logic [DIST_W-1:0]               rdist_q, rdist_d;

    assign unit_stall   = rv_q & ~rsp_ready;
    assign unit_payload = pay_q;
    assign rsp_valid    = rv_q;
    assign rsp_id       = rid_q;
    assign rsp_hit      = rhit_q;
    assign rsp_dist     = rdist_q;

    // Grant goes to the valid requester closest to ptr_q in rotation order.
    always_comb begin
        best    = NUM_REQ;
        dist_rr = 0;
        gnt_id  = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            dist_rr = (j - int'(ptr_q) + NUM_REQ) % NUM_REQ;
            if (req_valid[j] && dist_rr < best) begin
                best   = dist_rr;
                gnt_id = ID_W'(j);
            end
        end
        gnt       = rst_n & ~unit_stall & ~flush & (best < NUM_REQ);
        req_ready = gnt ? NUM_REQ'(1) << gnt_id : '0;
        ptr_d     = gnt ? ((int'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + 1'b1) : ptr_q;
    end

    always_comb begin
        pay_d   = pay_q;
        tv_d    = tv_q;
        tid_d   = tid_q;
        rv_d    = rv_q;
        rid_d   = rid_q;
        rhit_d  = rhit_q;
        rdist_d = rdist_q;
        if (flush) begin
            tv_d = '0;
            rv_d = 1'b0;
        end else if (!unit_stall) begin
            for (int k = UNIT_LAT - 1; k > 0; k--) begin
                tv_d[k]  = tv_q[k-1];
                tid_d[k] = tid_q[k-1];
            end
            tv_d[0]  = gnt;
            tid_d[0] = gnt_id;
            for (int k = 0; k < NUM_REQ; k++)
                if (gnt && gnt_id == ID_W'(k)) pay_d = req_payload[k*PAYLOAD_W +: PAYLOAD_W];
            // The unit's outputs line up with the last tag stage.
            rv_d = tv_q[UNIT_LAT-1];
            if (tv_q[UNIT_LAT-1]) begin
                rid_d   = tid_q[UNIT_LAT-1];
                rhit_d  = unit_hit;
                rdist_d = unit_dist;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            pay_q   <= '0;
            tv_q    <= '0;
            tid_q   <= '0;
            rv_q    <= 1'b0;
            rid_q   <= '0;
            rhit_q  <= 1'b0;
            rdist_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            pay_q   <= pay_d;
            tv_q    <= tv_d;
            tid_q   <= tid_d;
            rv_q    <= rv_d;
            rid_q   <= rid_d;
            rhit_q  <= rhit_d;
            rdist_q <= rdist_d;
        end
    end

`ifdef BBOX_SCHED_PERF_EN
    logic [31:0] iss_q, iss_d, hits_q, hits_d, stc_q, stc_d;

    assign perf_issued       = iss_q;
    assign perf_hits         = hits_q;
    assign perf_stall_cycles = stc_q;

    always_comb begin
        iss_d  = iss_q + 32'(gnt & ~&iss_q);
        hits_d = hits_q + 32'(rv_q & rsp_ready & rhit_q & ~&hits_q);
        stc_d  = stc_q + 32'(unit_stall & ~&stc_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_q  <= '0;
            hits_q <= '0;
            stc_q  <= '0;
        end else begin
            iss_q  <= iss_d;
            hits_q <= hits_d;
            stc_q  <= stc_d;
        end
    end
`endif
endmodule

// File: tb/tb_bbox_test_scheduler.sv
// tb_bbox_test_scheduler: randomized bench with a queue-based reference model and a stand-in intersect unit.
module tb_bbox_test_scheduler;
    localparam int NUM_REQ   = 4;
    localparam int ID_W      = 2;
    localparam int PAYLOAD_W = 512;
    localparam int UNIT_LAT  = 2;
    localparam int DIST_W    = 49;

    logic                         clk = 1'b0;
    logic                         rst_n = 1'b1;
    logic [NUM_REQ-1:0]           req_valid = '0;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ*PAYLOAD_W-1:0] req_payload = '0;
    logic                         flush = 1'b0;
    logic [PAYLOAD_W-1:0]         unit_payload;
    logic                         unit_stall;
    logic                         unit_hit;
    logic [DIST_W-1:0]            unit_dist;
    logic                         rsp_valid;
    logic                         rsp_ready = 1'b1;
    logic [ID_W-1:0]              rsp_id;
    logic                         rsp_hit;
    logic [DIST_W-1:0]            rsp_dist;

    int n_chk = 0;
    int n_pass = 0;

    bbox_test_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .PAYLOAD_W(PAYLOAD_W),
                          .UNIT_LAT(UNIT_LAT), .DIST_W(DIST_W)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_payload(req_payload), .flush(flush), .unit_payload(unit_payload),
        .unit_stall(unit_stall), .unit_hit(unit_hit), .unit_dist(unit_dist),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_hit(rsp_hit), .rsp_dist(rsp_dist)
    );

    always #5 clk = ~clk;

    // Golden box-test result as a pure function of the operands.
    function automatic logic g_hit(input logic [PAYLOAD_W-1:0] p);
        return ^p[PAYLOAD_W-1 -: 64];
    endfunction
    function automatic logic [DIST_W-1:0] g_dist(input logic [PAYLOAD_W-1:0] p);
        return p[DIST_W-1:0];
    endfunction

    // Stand-in intersect unit: samples operands when not stalled, result valid UNIT_LAT-1 samples later.
    logic [PAYLOAD_W-1:0] u_q [UNIT_LAT-1];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < UNIT_LAT - 1; k++) u_q[k] <= '0;
        end else if (!unit_stall) begin
            u_q[0] <= unit_payload;
            for (int k = 1; k < UNIT_LAT - 1; k++) u_q[k] <= u_q[k-1];
        end
    end
    assign unit_hit  = g_hit(u_q[UNIT_LAT-2]);
    assign unit_dist = g_dist(u_q[UNIT_LAT-2]);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    typedef struct {
        int                   id;
        logic [PAYLOAD_W-1:0] p;
        int                   cnt;
    } ent_t;

    ent_t                 m_q[$];
    int                   m_ptr = 0;
    logic                 m_rv = 1'b0;
    int                   m_id = 0;
    logic [PAYLOAD_W-1:0] m_p = '0;

    // Reference model: in-flight tests count down non-stalled cycles until they land in the response slot.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_q.delete();
            m_ptr = 0;
            m_rv  = 1'b0;
        end else begin
            logic stall;
            int   g;
            stall = m_rv & ~rsp_ready;
            g = -1;
            if (!stall && !flush)
                for (int k = 0; k < NUM_REQ; k++)
                    if (g < 0 && req_valid[(m_ptr + k) % NUM_REQ]) g = (m_ptr + k) % NUM_REQ;
            chk("req_ready", 64'(req_ready), (g >= 0) ? 64'(1) << g : 64'(0));
            chk("unit_stall", 64'(unit_stall), 64'(stall));
            chk("rsp_valid", 64'(rsp_valid), 64'(m_rv));
            if (m_rv) begin
                chk("rsp_id", 64'(rsp_id), 64'(m_id));
                chk("rsp_hit", 64'(rsp_hit), 64'(g_hit(m_p)));
                chk("rsp_dist", 64'(rsp_dist), 64'(g_dist(m_p)));
            end
            if (flush) begin
                m_q.delete();
                m_rv = 1'b0;
            end else if (!stall) begin
                m_rv = 1'b0;
                foreach (m_q[i]) m_q[i].cnt--;
                if (m_q.size() > 0 && m_q[0].cnt == 0) begin
                    m_rv = 1'b1;
                    m_id = m_q[0].id;
                    m_p  = m_q[0].p;
                    void'(m_q.pop_front());
                end
                if (g >= 0) begin
                    m_q.push_back('{g, req_payload[g*PAYLOAD_W +: PAYLOAD_W], UNIT_LAT});
                    m_ptr = (g + 1) % NUM_REQ;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_payloads();
        for (int i = 0; i < NUM_REQ * PAYLOAD_W / 32; i++) req_payload[i*32 +: 32] = $urandom();
    endtask

    initial begin
        logic [PAYLOAD_W-1:0] pat;
        int                   lat;
        #1 rst_n = 1'b0;
        req_valid = '1;
        rand_payloads();
        step();
        #1;
        chk("reset req_ready", 64'(req_ready), 64'(0));
        chk("reset rsp_valid", 64'(rsp_valid), 64'(0));
        chk("reset unit_stall", 64'(unit_stall), 64'(0));
        chk("reset unit_payload", 64'(unit_payload[63:0]), 64'(0));
        chk("reset rsp_dist", 64'(rsp_dist), 64'(0));
        chk("reset rsp_id", 64'(rsp_id), 64'(0));
        req_valid = '0;
        step();
        rst_n = 1'b1;
        step();

        // Single request from requester 2 with a hit at negative distance.
        pat = '0;
        pat[PAYLOAD_W-1] = 1'b1;
        pat[DIST_W-1] = 1'b1;
        pat[0] = 1'b1;
        req_payload[2*PAYLOAD_W +: PAYLOAD_W] = pat;
        req_valid = 4'b0100;
        #1;
        chk("single grant", 64'(req_ready), 64'(4'b0100));
        step();
        req_valid = '0;
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            step();
            lat++;
        end
        chk("single latency", 64'(lat), 64'(3));
        chk("single id", 64'(rsp_id), 64'(2));
        chk("single hit", 64'(rsp_hit), 64'(1));
        chk("single dist", 64'(rsp_dist), 64'(49'h1_0000_0000_0001));
        step();

        // All requesters valid: rotation continues from pointer 3.
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            rand_payloads();
            #1;
            chk("rotation", 64'(req_ready), 64'(1) << ((3 + k) % 4));
            step();
        end
        req_valid = '0;
        repeat (5) step();

        // Backpressure with three tests in flight.
        req_valid = '1;
        repeat (3) begin
            rand_payloads();
            step();
        end
        req_valid = '0;
        rsp_ready = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 10) begin
            step();
            lat++;
        end
        chk("stall rsp_valid", 64'(rsp_valid), 64'(1));
        req_valid = '1;
        repeat (5) begin
            #1;
            chk("stall unit_stall", 64'(unit_stall), 64'(1));
            chk("stall req_ready", 64'(req_ready), 64'(0));
            step();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (8) step();

        // Flush with a result pending and more in flight.
        req_valid = '1;
        repeat (3) begin
            rand_payloads();
            step();
        end
        flush = 1'b1;
        #1;
        chk("flush rsp_valid before", 64'(rsp_valid), 64'(1));
        chk("flush no grant", 64'(req_ready), 64'(0));
        step();
        flush = 1'b0;
        req_valid = '0;
        repeat (5) begin
            chk("flush no stale", 64'(rsp_valid), 64'(0));
            step();
        end
        req_valid = '1;
        repeat (4) begin
            rand_payloads();
            step();
        end
        req_valid = '0;
        repeat (4) step();

        // Asynchronous reset in the middle of a stream.
        req_valid = '1;
        repeat (4) begin
            rand_payloads();
            step();
        end
        #1 rst_n = 1'b0;
        #1;
        chk("async rsp_valid", 64'(rsp_valid), 64'(0));
        chk("async req_ready", 64'(req_ready), 64'(0));
        chk("async unit_payload", 64'(unit_payload[63:0]), 64'(0));
        chk("async rsp_id", 64'(rsp_id), 64'(0));
        step();
        req_valid = '0;
        #1 rst_n = 1'b1;
        repeat (5) begin
            step();
            chk("post reset quiet", 64'(rsp_valid), 64'(0));
        end

        // Random traffic; the model checks every cycle.
        repeat (3000) begin
            req_valid = NUM_REQ'($urandom());
            rsp_ready = ($urandom_range(3) != 0);
            flush = ($urandom_range(49) == 0);
            rand_payloads();
            step();
        end
        flush = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (8) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
